// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the EX-stage flag/branch unit: ALU op encodings,
// flag bit positions, branch condition codes, FSM state and the per-op
// flag update mask.
package flag_branch_unit_pkg;

  localparam int unsigned FLAG_W    = 3;
  localparam int unsigned ALU_CTL_W = 3;
  localparam int unsigned CCC_W     = 3;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 2;

  typedef enum logic [ALU_CTL_W-1:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_PADDSB = 3'b010,
    ALU_RED    = 3'b011,
    ALU_SLL    = 3'b100,
    ALU_SRA    = 3'b101,
    ALU_ROR    = 3'b110,
    ALU_XOR    = 3'b111
  } alu_op_e;

  typedef enum logic [CCC_W-1:0] {
    CC_NE     = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } cc_e;

  // Flag payload; member order matches the bus bit order Z/V/N = [2]/[1]/[0].
  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } fbu_state_e;

  // Which flag bits each ALU op is allowed to write.
  function automatic logic [FLAG_W-1:0] flag_update_mask(input logic [ALU_CTL_W-1:0] ctl);
    logic [FLAG_W-1:0] mask;
    mask = '0;
    case (alu_op_e'(ctl))
      ALU_ADD, ALU_SUB:                  mask = 3'b111;
      ALU_SLL, ALU_SRA, ALU_ROR, ALU_XOR: mask = 3'b100;
      ALU_PADDSB, ALU_RED:               mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/flag_branch_unit_br_cond_eval.sv
// br_cond_eval: combinational branch condition decode.
// Ports:
//   i_flags  [2:0]  flags, [2]=Z [1]=V [0]=N
//   i_ccc    [2:0]  branch condition code
//   o_cond          condition satisfied
module br_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [FLAG_W-1:0] i_flags,
  input  logic [CCC_W-1:0]  i_ccc,
  output logic              o_cond
);

  alu_flags_t w_f;

  always_comb begin
    w_f    = alu_flags_t'(i_flags);
    o_cond = 1'b0;
    case (cc_e'(i_ccc))
      CC_NE:     o_cond = ~w_f.z;
      CC_EQ:     o_cond = w_f.z;
      CC_GT:     o_cond = ~w_f.z & ~w_f.n;
      // Z=1 or (Z=0 and N=0) reduces to Z=1 or N=0.
      CC_GTE:    o_cond = w_f.z | ~w_f.n;
      CC_LT:     o_cond = w_f.n;
      CC_LTE:    o_cond = w_f.n | w_f.z;
      CC_OVFL:   o_cond = w_f.v;
      CC_UNCOND: o_cond = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: latches ALU flags under a per-op mask, evaluates branch
// conditions and sequences the post-branch flush of IF/ID.
// Optional feature macro: FLAG_BYPASS_EN (same-cycle flag bypass to the
// branch evaluator; br_stall tied 0). Undefined: a branch coinciding with a
// flag write stalls one cycle.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   alu_flags [2:0]   ALU flags Z/V/N
//   alu_ctl   [2:0]   ALU op code
//   flag_we           flag-writing ALU op in EX
//   br_valid          conditional branch in EX
//   br_ccc    [2:0]   branch condition code
//   flags_q   [2:0]   registered flags
//   br_taken          combinational redirect pulse
//   flush             registered IF/ID squash
//   br_stall          combinational hold-branch request
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLAG_W-1:0]    alu_flags,
  input  logic [ALU_CTL_W-1:0] alu_ctl,
  input  logic                 flag_we,
  input  logic                 br_valid,
  input  logic [CCC_W-1:0]     br_ccc,
  output logic [FLAG_W-1:0]    flags_q,
  output logic                 br_taken,
  output logic                 flush,
  output logic                 br_stall
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

  fbu_state_e        r_state;
  fbu_state_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_flush;
  logic [FLAG_W-1:0] r_flags;
  logic [FLAG_W-1:0] w_mask;
  logic [FLAG_W-1:0] w_flags_merged;
  logic [FLAG_W-1:0] w_flags_eff;
  logic              w_idle;
  logic              w_flag_wr;
  logic              w_stall;
  logic              w_cond;
  logic              w_taken;

  assign w_idle         = (r_state == ST_IDLE);
  assign w_flag_wr      = flag_we & w_idle;
  assign w_mask         = flag_update_mask(alu_ctl);
  assign w_flags_merged = (r_flags & ~w_mask) | (alu_flags & w_mask);

`ifdef FLAG_BYPASS_EN
  assign w_flags_eff = w_flag_wr ? w_flags_merged : r_flags;
  assign w_stall     = 1'b0;
`else
  assign w_flags_eff = r_flags;
  // Flags are in flight this cycle: hold the branch until they land.
  assign w_stall     = w_idle & br_valid & flag_we;
`endif

  br_cond_eval u_cond (
    .i_flags (w_flags_eff),
    .i_ccc   (br_ccc),
    .o_cond  (w_cond)
  );

  // Branches arriving during FLUSH are squashed bubbles and never taken.
  assign w_taken = w_idle & br_valid & ~w_stall & w_cond;

  // Flag register; writes are suppressed while younger ops are being flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_flag_wr) begin
      r_flags <= w_flags_merged;
    end
  end

  // State register, flush counter and registered flush output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_flush <= (w_state_nxt == ST_FLUSH);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_taken) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CNT_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
    endcase
  end

  // Outputs.
  always_comb begin
    flags_q  = r_flags;
    flush    = r_flush;
    br_taken = w_taken;
    br_stall = w_stall;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the ALU result/flags interface in the 16-bit single-cycle/EX-stage datapath.
- Latches the ALU N/V/Z flags under a per-opcode update mask.
- Evaluates the 3-bit branch condition code against those flags.
- Sequences the post-branch flush of younger instructions with a small FSM and counter.
- Sits beside the ALU in EX and drives the PC-redirect and flush controls.

Parameters:
- FLUSH_CYCLES, 2, cycles that flush stays high after a taken branch; legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_flags  in  3  ALU flags: [2]=Z, [1]=V, [0]=N.
- alu_ctl  in  3  ALU op code: 000 ADD, 001 SUB, 010 PADDSB, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 XOR.
- flag_we  in  1  an EX-stage instruction this cycle is a flag-writing ALU op.
- br_valid  in  1  an EX-stage conditional branch (B/BR) this cycle.
- br_ccc  in  3  branch condition code.
- flags_q  out  3  registered flags, same bit order as alu_flags.
- br_taken  out  1  one-cycle pulse: redirect PC to the branch target.
- flush  out  1  squash IF/ID contents.
- br_stall  out  1  hold the branch in EX one more cycle.

Behaviour:
- Reset (async, rst_n=0):
  - flags_q=000, br_taken=0, flush=0, br_stall=0.
  - FSM=IDLE, counter=0.
  - Asserting reset mid-flush aborts the flush immediately.
- Update mask, by alu_ctl:
  - ADD/SUB write N, V, Z.
  - SLL/SRA/ROR/XOR write Z only.
  - PADDSB/RED write nothing.
  - Flags are written on the clock edge where flag_we=1 and FSM=IDLE; unmasked bits hold.
- Conditions, evaluated on the effective flags:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or (Z=0 and N=0).
  - 101 LTE: N=1 or Z=1.
  - 110 OVFL: V=1.
  - 111 always.
- Effective flags: flags_q, except where the optional bypass below applies.
- FSM IDLE:
  - br_valid=1, not stalled, condition true: br_taken=1 combinationally this cycle; next state FLUSH with counter=FLUSH_CYCLES.
  - Condition false: no action, stay IDLE.
- FSM FLUSH:
  - flush=1 (registered output).
  - br_valid and flag_we are ignored, since those instructions are squashed bubbles.
  - Counter decrements each cycle; on the cycle the counter reaches 1, next state is IDLE.
  - Result: flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after br_taken.
- br_taken is never asserted while in FLUSH.
- Simultaneous flag_we and br_valid in IDLE: the flag write always completes; branch handling is defined by the optional feature.
- Back-to-back taken branches: the second branch arrives during FLUSH and is dropped by design.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined:
  - The effective flags for branch evaluation are flags_q with the masked alu_flags merged in when flag_we=1 in the same cycle.
  - br_stall is tied 0.
- Undefined:
  - When br_valid and flag_we are both 1 in IDLE, br_stall=1 for that cycle, the condition is not evaluated, and br_taken=0.
  - Upstream holds the branch in EX; next cycle it is evaluated against the updated flags_q.
  - br_stall is never asserted in FLUSH or when flag_we=0.

Decomposition:
- Shared package holds:
  - ALU op encodings (ALU_ADD..ALU_XOR).
  - Flag bit indices (FLAG_N=0, FLAG_V=1, FLAG_Z=2).
  - Condition code constants (CC_NE..CC_UNCOND).
- One sub-module, br_cond_eval: purely combinational condition decode from 3-bit flags and ccc to a single cond bit. It is reused by the BR register-branch path.

Test Plan:
- Reset, then ADD with alu_flags=111 and flag_we=1 -> flags_q=111 next cycle; SLL with alu_flags=000 -> flags_q=011 (only Z written); RED with alu_flags=100 -> flags_q unchanged.
- flags_q=001 (N=1), br_valid, ccc=011 LT -> br_taken=1 same cycle; flush=1 for exactly 2 cycles (default); br_valid with ccc=111 during flush -> br_taken stays 0.
- flags_q=000, ccc=010 GT -> taken; flags_q=100, ccc=010 -> not taken and flush stays 0; ccc=110 with V=1 -> taken.
- Same-cycle SUB (alu_flags=100, flag_we=1) and branch ccc=001 EQ, with flags_q=000:
  - With FLAG_BYPASS_EN: br_taken=1 that cycle.
  - Without: br_stall=1 and br_taken=0; next cycle (branch held, flag_we=0) br_taken=1.
- FLUSH_CYCLES=3 taken branch; deassert rst_n during the second flush cycle -> flush=0 and flags_q=000 immediately; after release, a branch with ccc=001 is not taken.
- XOR with alu_flags=011 and flag_we=1 in the cycle right after a taken branch (FSM in FLUSH) -> flags_q unchanged.
